// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring division producing one quotient bit per clock. Division by zero
// and signed overflow are resolved at accept and finish on the next cycle.
// The result register and the valid pulse are updated on the edge that
// enters FIN, so valid and res are both registered outputs.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] res
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    // Two's-complement negate when en is set, pass-through otherwise.
    // Negating MIN gives MIN, which is the right unsigned magnitude.
    function automatic logic [WIDTH-1:0] cond_neg(input logic en, input logic [WIDTH-1:0] v);
        if (en) begin
            return ~v + ONE;
        end else begin
            return v;
        end
    endfunction

    state_t           state_r, state_s;
    logic [1:0]       op_r, op_s;
    logic             sign_a_r, sign_a_s;
    logic             sign_b_r, sign_b_s;
    logic [WIDTH-1:0] rem_r, rem_s;
    logic [WIDTH-1:0] quo_r, quo_s;
    logic [WIDTH-1:0] div_r, div_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             valid_r, valid_s;
    logic [WIDTH-1:0] res_r, res_s;

    // The partial remainder always stays below the divisor, so WIDTH bits hold
    // it between iterations; the shifted trial value needs one extra bit.
    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   diff_s;
    logic             q_bit_s;
    logic [WIDTH-1:0] step_rem_s;
    logic [WIDTH-1:0] step_quo_s;
    logic             neg_quo_s;
    logic             neg_rem_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;

    // One restoring iteration plus the sign-fixup controls for the latched op.
    always_comb begin
        trial_s    = {rem_r, quo_r[WIDTH-1]};
        diff_s     = trial_s - {1'b0, div_r};
        q_bit_s    = ~diff_s[WIDTH];
        if (q_bit_s) begin
            step_rem_s = diff_s[WIDTH-1:0];
        end else begin
            step_rem_s = trial_s[WIDTH-1:0];
        end
        step_quo_s = {quo_r[WIDTH-2:0], q_bit_s};
        neg_quo_s  = ~op_r[0] & (sign_a_r ^ sign_b_r);
        neg_rem_s  = ~op_r[0] & sign_a_r;
        mag_a_s    = cond_neg(~op[0] & a[WIDTH-1], a);
        mag_b_s    = cond_neg(~op[0] & b[WIDTH-1], b);
    end

    // Next-state and next-register values for the IDLE/RUN/FIN controller.
    always_comb begin
        state_s  = state_r;
        op_s     = op_r;
        sign_a_s = sign_a_r;
        sign_b_s = sign_b_r;
        rem_s    = rem_r;
        quo_s    = quo_r;
        div_s    = div_r;
        cnt_s    = cnt_r;
        valid_s  = 1'b0;
        res_s    = res_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_s     = op;
                    sign_a_s = a[WIDTH-1];
                    sign_b_s = b[WIDTH-1];
                    rem_s    = ZERO;
                    quo_s    = mag_a_s;
                    div_s    = mag_b_s;
                    cnt_s    = CNT_ZERO;
                    if (b == ZERO) begin
                        state_s = ST_FIN;
                        valid_s = 1'b1;
                        res_s   = op[1] ? a : ALL_ONES;
                    end else if (!op[0] && (a == MIN_VAL) && (b == ALL_ONES)) begin
                        state_s = ST_FIN;
                        valid_s = 1'b1;
                        res_s   = op[1] ? ZERO : MIN_VAL;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_s = ST_IDLE;
                end else begin
                    rem_s = step_rem_s;
                    quo_s = step_quo_s;
                    cnt_s = cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        state_s = ST_FIN;
                        valid_s = 1'b1;
                        if (op_r[1]) begin
                            res_s = cond_neg(neg_rem_s, step_rem_s);
                        end else begin
                            res_s = cond_neg(neg_quo_s, step_quo_s);
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            op_r     <= 2'b00;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            rem_r    <= ZERO;
            quo_r    <= ZERO;
            div_r    <= ZERO;
            cnt_r    <= CNT_ZERO;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            res_r    <= ZERO;
        end else begin
            state_r  <= state_s;
            op_r     <= op_s;
            sign_a_r <= sign_a_s;
            sign_b_r <= sign_b_s;
            rem_r    <= rem_s;
            quo_r    <= quo_s;
            div_r    <= div_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            valid_r  <= valid_s;
            res_r    <= res_s;
        end
    end

    assign busy  = busy_r;
    assign valid = valid_r;
    assign res   = res_r;

endmodule
